// File: rtl/csr_pkg.sv
// Shared types and widths for the CSR access arbiter slice.
package csr_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int CSR_DATA_W = 32;

  // One requester's access as seen by the arbiter.
  typedef struct packed {
    logic                  write;
    logic                  lock;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] wdata;
  } csr_req_t;

  // Bus lock state: either open arbitration or reserved for one owner.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or above ptr (wrapping) that is
// both requesting and allowed by mask. Returns one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Scan NUM_REQ slots starting at ptr and take the first eligible one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      logic [IDX_W-1:0] jj;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!gnt_any && req[jj] && mask[jj]) begin
        gnt_any = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Shares one CSR read port and one CSR write port between NUM_REQ
// requesters: round-robin grant, one-hot registered response, optional
// bus lock for read-modify-write sequences, and a lock watchdog.
module csr_access_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*CSR_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*CSR_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [CSR_DATA_W-1:0]         rsp_rdata,
  output logic                          csr_read,
  output logic [CSR_ADDR_W-1:0]         csr_read_addr,
  input  logic [CSR_DATA_W-1:0]         csr_read_data,
  output logic                          csr_write,
  output logic [CSR_ADDR_W-1:0]         csr_write_addr,
  output logic [CSR_DATA_W-1:0]         csr_write_data,
  output logic                          lock_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int WD_LIMIT = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;
  localparam logic [31:0] WD_LIMIT_V = WD_LIMIT;
  localparam logic [WD_W-1:0] WD_MAX = WD_LIMIT_V[WD_W-1:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  csr_req_t          reqs [NUM_REQ];
  csr_req_t          sel;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] owner_oh;
  logic              owner_valid;
  logic              owner_lock;

  lock_state_t       state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [IDX_W-1:0]  rr_ptr_q;

  logic [NUM_REQ-1:0] rsp_vld_p1;
  logic              rsp_rd_p1;

  // Unpack flat request buses, decode the lock owner and pick the granted request.
  always_comb begin
    sel      = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].write = req_write[i];
      reqs[i].lock  = req_lock[i];
      reqs[i].addr  = req_addr[CSR_ADDR_W*i +: CSR_ADDR_W];
      reqs[i].wdata = req_wdata[CSR_DATA_W*i +: CSR_DATA_W];
      owner_oh[i]   = (owner_q == IDX_W'(i));
      if (gnt[i]) sel = reqs[i];
    end
    owner_valid = |(req_valid & owner_oh);
    owner_lock  = |(req_lock & owner_oh);
    mask        = (state_q == LOCKED) ? owner_oh : '1;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .mask    (mask),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Drive the CSR ports from the granted request; idle ports read as zero.
  always_comb begin
    req_ready      = gnt;
    csr_read       = gnt_any && !sel.write;
    csr_write      = gnt_any && sel.write;
    csr_read_addr  = csr_read  ? sel.addr  : '0;
    csr_write_addr = csr_write ? sel.addr  : '0;
    csr_write_data = csr_write ? sel.wdata : '0;
    rsp_valid      = rsp_vld_p1;
    rsp_rdata      = rsp_rd_p1 ? csr_read_data : '0;
  end

  // Lock FSM next state and watchdog; timeout pulses in the releasing cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wd_d         = wd_q;
    lock_timeout = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (gnt_any && sel.lock) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
          wd_d    = '0;
        end
      end
      LOCKED: begin
        if (gnt_any) begin
          wd_d = '0;
          if (!sel.lock) state_d = UNLOCKED;
        end else if (!owner_valid && !owner_lock) begin
          state_d = UNLOCKED;
          wd_d    = '0;
        end else if (LOCK_TIMEOUT != 0) begin
          if (wd_q == WD_MAX) begin
            state_d      = UNLOCKED;
            lock_timeout = 1'b1;
            wd_d         = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Control state: lock FSM, watchdog and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      owner_q  <= '0;
      wd_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      if (gnt_any) rr_ptr_q <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Response stage: one-hot completion and read/write select, one cycle after grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= '0;
      rsp_rd_p1  <= 1'b0;
    end else begin
      rsp_vld_p1 <= gnt;
      rsp_rd_p1  <= csr_read;
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a behavioural CSR storage model.
module tb_csr_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, req_lock, req_ready, rsp_valid;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, csr_read_data, csr_write_data;
  logic        csr_read, csr_write, lock_timeout;
  logic [11:0] csr_read_addr, csr_write_addr;

  logic [31:0] mem [4096];
  int n_assert = 0;
  int n_fail   = 0;

  csr_access_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_lock       (req_lock),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .csr_read       (csr_read),
    .csr_read_addr  (csr_read_addr),
    .csr_read_data  (csr_read_data),
    .csr_write      (csr_write),
    .csr_write_addr (csr_write_addr),
    .csr_write_data (csr_write_data),
    .lock_timeout   (lock_timeout)
  );

  always #5 clk = ~clk;

  // CSR storage: synchronous read, write on the same edge.
  always @(posedge clk) begin
    if (csr_read)  csr_read_data <= mem[csr_read_addr];
    if (csr_write) mem[csr_write_addr] <= csr_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks happen at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'h00000005;
    csr_read_data = '0;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    next_cycle(); next_cycle(); settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_timeout", 32'(lock_timeout), 32'h0);
    chk("rst_csr_read", 32'(csr_read), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Contention: both read continuously, grants alternate from 0
    next_cycle();
    req_valid = 2'b11; req_addr = {12'h020, 12'h010};
    settle();
    chk("cont1_ready", 32'(req_ready), 32'h1);
    chk("cont1_raddr", 32'(csr_read_addr), 32'h010);
    next_cycle(); settle();
    chk("cont2_ready", 32'(req_ready), 32'h2);
    chk("cont2_raddr", 32'(csr_read_addr), 32'h020);
    chk("cont2_rsp", 32'(rsp_valid), 32'h1);
    chk("cont2_rdata", rsp_rdata, 32'hDEADBEEF);
    next_cycle(); settle();
    chk("cont3_ready", 32'(req_ready), 32'h1);
    chk("cont3_rsp", 32'(rsp_valid), 32'h2);
    chk("cont3_rdata", rsp_rdata, 32'h00000005);
    next_cycle(); settle();
    chk("cont4_ready", 32'(req_ready), 32'h2);
    chk("cont4_rsp", 32'(rsp_valid), 32'h1);
    next_cycle();
    req_valid = 2'b00;
    settle();
    chk("cont5_ready", 32'(req_ready), 32'h0);
    chk("cont5_rsp", 32'(rsp_valid), 32'h2);
    chk("cont5_csr_read", 32'(csr_read), 32'h0);

    // Single read of 0x010 by req0
    next_cycle();
    req_valid = 2'b01; req_addr = {12'h000, 12'h010};
    settle();
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_csr_read", 32'(csr_read), 32'h1);
    chk("rd_csr_write", 32'(csr_write), 32'h0);
    next_cycle();
    req_valid = 2'b00;
    settle();
    chk("rd_rsp", 32'(rsp_valid), 32'h1);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);

    // req1 writes 0x7FF then reads it back
    next_cycle();
    req_valid = 2'b10; req_write = 2'b10;
    req_addr = {12'h7FF, 12'h000}; req_wdata = {32'h12345678, 32'h0};
    settle();
    chk("wr_ready", 32'(req_ready), 32'h2);
    chk("wr_csr_write", 32'(csr_write), 32'h1);
    chk("wr_waddr", 32'(csr_write_addr), 32'h7FF);
    chk("wr_wdata", csr_write_data, 32'h12345678);
    chk("wr_csr_read", 32'(csr_read), 32'h0);
    next_cycle();
    req_write = 2'b00;
    settle();
    chk("rb_csr_read", 32'(csr_read), 32'h1);
    chk("rb_raddr", 32'(csr_read_addr), 32'h7FF);
    chk("wr_rsp", 32'(rsp_valid), 32'h2);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    next_cycle();
    req_valid = 2'b00;
    settle();
    chk("rb_rdata", rsp_rdata, 32'h12345678);

    // Locked read-modify-write by req0 while req1 waits
    next_cycle();
    req_valid = 2'b11; req_lock = 2'b01; req_addr = {12'h010, 12'h020};
    settle();
    chk("rmw_rd_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 2'b10;
    settle();
    chk("rmw_hold_ready", 32'(req_ready), 32'h0);
    chk("rmw_rd_rdata", rsp_rdata, 32'h00000005);
    next_cycle();
    req_valid = 2'b11; req_write = 2'b01; req_lock = 2'b00;
    req_wdata = {32'h0, 32'h00000006};
    settle();
    chk("rmw_wr_ready", 32'(req_ready), 32'h1);
    chk("rmw_wr_data", csr_write_data, 32'h00000006);
    next_cycle();
    req_valid = 2'b10; req_write = 2'b00;
    settle();
    chk("rmw_after_ready", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 2'b00;
    settle();
    chk("rmw_after_rdata", rsp_rdata, 32'hDEADBEEF);

    // Watchdog: req0 locks then idles holding lock
    next_cycle();
    req_valid = 2'b01; req_lock = 2'b01;
    settle();
    chk("wd_lock_ready", 32'(req_ready), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      req_valid = 2'b10;
      settle();
      chk("wd_wait_ready", 32'(req_ready), 32'h0);
      chk("wd_wait_timeout", 32'(lock_timeout), 32'h0);
    end
    next_cycle(); settle();
    chk("wd_pulse", 32'(lock_timeout), 32'h1);
    chk("wd_pulse_ready", 32'(req_ready), 32'h0);
    next_cycle(); settle();
    chk("wd_release_ready", 32'(req_ready), 32'h2);
    chk("wd_pulse_end", 32'(lock_timeout), 32'h0);

    // Reset in the cycle after a locking read grant
    next_cycle();
    req_valid = 2'b01; req_lock = 2'b01;
    settle();
    chk("mid_grant", 32'(req_ready), 32'h1);
    next_cycle();
    rst_n = 1'b0; req_valid = 2'b00; req_lock = 2'b00;
    settle();
    chk("mid_rsp_dropped", 32'(rsp_valid), 32'h0);
    chk("mid_rdata", rsp_rdata, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    req_valid = 2'b11;
    settle();
    chk("mid_ptr_reset", 32'(req_ready), 32'h1);
    chk("mid_rsp_still0", 32'(rsp_valid), 32'h0);
    next_cycle();
    req_valid = 2'b10;
    settle();
    chk("mid_lock_cleared", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 2'b00;
    settle();
    chk("mid_rsp_resume", 32'(rsp_valid), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
